// File: rtl/example_mul_pkg.sv
// Shared widths and result payload for the shared multiplier arbiter.
// The id field is sized for the largest supported requester count.
package example_mul_pkg;

  localparam int unsigned MUL_NREQ     = 4;
  localparam int unsigned MUL_A_W      = 14;
  localparam int unsigned MUL_B_W      = 10;
  localparam int unsigned MUL_P_W      = 21;
  localparam int unsigned MUL_ID_W     = $clog2(MUL_NREQ);
  localparam int unsigned MUL_ID_MAX_W = 3;

  typedef struct packed {
    logic [MUL_P_W-1:0]      p;
    logic [MUL_ID_MAX_W-1:0] id;
  } mul_res_t;

endpackage

// File: rtl/example_mul_core.sv
// Combinational signed A times zero-extended unsigned B, truncated to P_W bits.
module example_mul_core
  import example_mul_pkg::*;
#(
  parameter int unsigned A_W = MUL_A_W,
  parameter int unsigned B_W = MUL_B_W,
  parameter int unsigned P_W = MUL_P_W
) (
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic [P_W-1:0] p
);

  localparam int unsigned F_W = A_W + B_W + 1;

  logic signed [F_W-1:0] a_ext;
  logic signed [F_W-1:0] b_ext;
  logic signed [F_W-1:0] full;

  // Full-width signed product; only the low P_W bits leave the core.
  always_comb begin
    a_ext = F_W'($signed(a));
    b_ext = F_W'(b);
    full  = a_ext * b_ext;
    p     = full[P_W-1:0];
  end

endmodule

// File: rtl/example_mul_arbiter.sv
// Round-robin arbiter feeding one shared multiplier through a two-stage
// pipeline (operand register, product register) with a backpressured result port.
module example_mul_arbiter
  import example_mul_pkg::*;
#(
  parameter int unsigned NREQ = MUL_NREQ,
  parameter int unsigned A_W  = MUL_A_W,
  parameter int unsigned B_W  = MUL_B_W,
  parameter int unsigned P_W  = MUL_P_W,
  parameter int unsigned ID_W = $clog2(NREQ)
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*A_W-1:0] req_a,
  input  logic [NREQ*B_W-1:0] req_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [P_W-1:0]    res_p,
  output logic [ID_W-1:0]   res_id,
  output logic              busy,
  output logic [15:0]       ops_count
);

  logic            s1_valid;
  logic [A_W-1:0]  s1_a;
  logic [B_W-1:0]  s1_b;
  logic [ID_W-1:0] s1_id;
  logic [ID_W-1:0] rr;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] idx;
  logic            found;
  logic            any_valid;
  logic            out_load;
  logic            s1_free;
  logic            grant;
  logic [P_W-1:0]  core_p;
  logic [15:0]     ops_q;
  mul_res_t        res_q;

  // First valid requester at or after the rotating pointer.
  always_comb begin
    winner = rr;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = ID_W'((32'(rr) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // Stage 1 frees up in the same cycle its contents move to the output register.
  always_comb begin
    any_valid = |req_valid;
    out_load  = s1_valid && (!res_valid || res_ready);
    s1_free   = !s1_valid || out_load;
    grant     = any_valid && s1_free && ap_rst_n;
  end

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[winner] = 1'b1;
  end

  // Operand stage, pointer and accept counter.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
      rr       <= '0;
      ops_q    <= '0;
    end else if (grant) begin
      s1_valid <= 1'b1;
      s1_a     <= req_a[32'(winner)*A_W +: A_W];
      s1_b     <= req_b[32'(winner)*B_W +: B_W];
      s1_id    <= winner;
      rr       <= (32'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
      ops_q    <= ops_q + 16'd1;
    end else if (out_load) begin
      s1_valid <= 1'b0;
    end
  end

  example_mul_core #(
    .A_W (A_W),
    .B_W (B_W),
    .P_W (P_W)
  ) u_core (
    .a (s1_a),
    .b (s1_b),
    .p (core_p)
  );

  // Output register; holds while the consumer stalls.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      res_valid <= 1'b0;
      res_q     <= '0;
    end else if (out_load) begin
      res_valid <= 1'b1;
      res_q.p   <= MUL_P_W'(core_p);
      res_q.id  <= MUL_ID_MAX_W'(s1_id);
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

  assign res_p     = P_W'(res_q.p);
  assign res_id    = res_q.id[ID_W-1:0];
  assign busy      = s1_valid || res_valid;
  assign ops_count = ops_q;

endmodule
